c7b_mem_arb: RTL and testbench

Two-requester arbiter sharing the single memory read/write port between the instruction fetch path (IFU→ICU) and the load/store unit. It uses the same req/ack (stage 1) and data_valid (stage 2) handshake that the IFU already drives, so each requester sees a private port. At most one transaction is outstanding. Contention is resolved round-robin, and the IFU can cancel an in-flight fetch on a pipeline flush.

---
 rtl/c7b_mem_arb_if.sv | 54 +++++
 rtl/c7b_mem_arb.sv | 92 +++++++++
 tb/tb_c7b_mem_arb.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c7b_mem_arb_if.sv
// Bundle of the fetch, load/store and downstream memory ports seen by the arbiter.
// The arbiter binds to the slave modport; the surrounding system drives the master modport.
interface c7b_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic            ifu_req;
    logic [AW-1:0]   ifu_addr;
    logic            ifu_cancel;
    logic            ifu_ack;
    logic            ifu_data_vld;
    logic [DW-1:0]   ifu_data;

    logic            lsu_req;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_wr;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wstrb;
    logic            lsu_ack;
    logic            lsu_data_vld;
    logic [DW-1:0]   lsu_data;

    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_wr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_ack;
    logic            mem_data_vld;
    logic [DW-1:0]   mem_data;

    // Debug view of the arbiter FSM: 0 = IDLE, 1 = WAIT_IFU, 2 = WAIT_LSU.
    logic [1:0]      arb_state;

    modport slave (
        input  ifu_req, ifu_addr, ifu_cancel,
        output ifu_ack, ifu_data_vld, ifu_data,
        input  lsu_req, lsu_addr, lsu_wr, lsu_wdata, lsu_wstrb,
        output lsu_ack, lsu_data_vld, lsu_data,
        output mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_data_vld, mem_data,
        output arb_state
    );

    modport master (
        output ifu_req, ifu_addr, ifu_cancel,
        input  ifu_ack, ifu_data_vld, ifu_data,
        output lsu_req, lsu_addr, lsu_wr, lsu_wdata, lsu_wstrb,
        input  lsu_ack, lsu_data_vld, lsu_data,
        input  mem_req, mem_addr, mem_wr, mem_wdata, mem_wstrb,
        output mem_ack, mem_data_vld, mem_data,
        input  arb_state
    );
endinterface

// File: rtl/c7b_mem_arb.sv
// Round-robin arbiter giving the IFU and the LSU private req/ack + data_vld ports onto one
// memory port, one transaction outstanding at a time, with fetch cancel on pipeline flush.
module c7b_mem_arb #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input logic                clk,
    input logic                resetn,
    c7b_mem_arb_if.slave       bus
);
    // Handshake: a requester holds req (and its payload) until ack, which is
    // mem_req & mem_ack for the granted side in the same cycle; the response is
    // a single-cycle data_vld some later cycle, combinational from mem_data_vld.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_IFU = 2'd1,
        WAIT_LSU = 2'd2
    } state_t;

    state_t state;
    logic   rr_last;   // 0 = IFU granted last, 1 = LSU granted last
    logic   drop;      // outstanding fetch was cancelled

    logic ifu_req_e;
    logic gnt_ifu;
    logic gnt_lsu;
    logic accept;
    logic ifu_vld;
    logic lsu_vld;

    // Outputs are qualified by resetn so everything reads 0 while reset is held.
    always_comb begin
        ifu_req_e = bus.ifu_req & ~bus.ifu_cancel;
        gnt_ifu   = 1'b0;
        gnt_lsu   = 1'b0;
        if (resetn && state == IDLE) begin
            if (ifu_req_e && bus.lsu_req) begin
                gnt_ifu = rr_last;
                gnt_lsu = ~rr_last;
            end else begin
                gnt_ifu = ifu_req_e;
                gnt_lsu = bus.lsu_req;
            end
        end
    end

    assign accept  = (gnt_ifu | gnt_lsu) & bus.mem_ack;
    assign ifu_vld = resetn & (state == WAIT_IFU) & bus.mem_data_vld & ~drop & ~bus.ifu_cancel;
    assign lsu_vld = resetn & (state == WAIT_LSU) & bus.mem_data_vld;

    assign bus.mem_req   = gnt_ifu | gnt_lsu;
    assign bus.mem_addr  = gnt_ifu ? bus.ifu_addr : (gnt_lsu ? bus.lsu_addr : '0);
    assign bus.mem_wr    = gnt_lsu & bus.lsu_wr;
    assign bus.mem_wdata = gnt_lsu ? bus.lsu_wdata : '0;
    assign bus.mem_wstrb = gnt_lsu ? bus.lsu_wstrb : '0;

    assign bus.ifu_ack      = gnt_ifu & bus.mem_ack;
    assign bus.lsu_ack      = gnt_lsu & bus.mem_ack;
    assign bus.ifu_data_vld = ifu_vld;
    assign bus.lsu_data_vld = lsu_vld;
    assign bus.ifu_data     = ifu_vld ? bus.mem_data : '0;
    assign bus.lsu_data     = lsu_vld ? bus.mem_data : '0;
    assign bus.arb_state    = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            drop    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Responses seen here are stale (e.g. after reset) and are ignored.
                    if (accept) begin
                        state   <= gnt_ifu ? WAIT_IFU : WAIT_LSU;
                        rr_last <= gnt_lsu;
                        drop    <= 1'b0;
                    end
                end
                WAIT_IFU: begin
                    if (bus.ifu_cancel) drop <= 1'b1;
                    if (bus.mem_data_vld) state <= IDLE;
                end
                WAIT_LSU: begin
                    if (bus.mem_data_vld) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c7b_mem_arb.sv
// Bench for c7b_mem_arb: cycle-by-cycle vector table plus scoreboarded sequences for
// contention, ack-stall preemption, in-flight cancel and reset mid-transaction.
module tb_c7b_mem_arb;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    c7b_mem_arb_if #(.AW(AW), .DW(DW)) bus ();
    c7b_mem_arb #(.AW(AW), .DW(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct packed {
        logic        ifu_req;
        logic [31:0] ifu_addr;
        logic        ifu_cancel;
        logic        lsu_req;
        logic [31:0] lsu_addr;
        logic        lsu_wr;
        logic [63:0] lsu_wdata;
        logic [7:0]  lsu_wstrb;
        logic        mem_ack;
        logic        mem_data_vld;
        logic [63:0] mem_data;
    } in_t;

    typedef struct packed {
        logic        ifu_ack;
        logic        ifu_data_vld;
        logic [63:0] ifu_data;
        logic        lsu_ack;
        logic        lsu_data_vld;
        logic [63:0] lsu_data;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic        mem_wr;
        logic [63:0] mem_wdata;
        logic [7:0]  mem_wstrb;
        logic [1:0]  state;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] ifu_q[$];
    logic [DW-1:0] lsu_q[$];
    logic [1:0]    gnt_q[$];   // {ifu_ack, lsu_ack} expected per accepted request
    int            n_vec;
    int            n_err;
    bit            sb_on;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got an unexpected output event, expected none", name);
    endtask

    function automatic out_t pack_out();
        out_t o;
        o.ifu_ack      = bus.ifu_ack;
        o.ifu_data_vld = bus.ifu_data_vld;
        o.ifu_data     = bus.ifu_data;
        o.lsu_ack      = bus.lsu_ack;
        o.lsu_data_vld = bus.lsu_data_vld;
        o.lsu_data     = bus.lsu_data;
        o.mem_req      = bus.mem_req;
        o.mem_addr     = bus.mem_addr;
        o.mem_wr       = bus.mem_wr;
        o.mem_wdata    = bus.mem_wdata;
        o.mem_wstrb    = bus.mem_wstrb;
        o.state        = bus.arb_state;
        return o;
    endfunction

    task automatic drive_in(input in_t x);
        bus.ifu_req      = x.ifu_req;
        bus.ifu_addr     = x.ifu_addr;
        bus.ifu_cancel   = x.ifu_cancel;
        bus.lsu_req      = x.lsu_req;
        bus.lsu_addr     = x.lsu_addr;
        bus.lsu_wr       = x.lsu_wr;
        bus.lsu_wdata    = x.lsu_wdata;
        bus.lsu_wstrb    = x.lsu_wstrb;
        bus.mem_ack      = x.mem_ack;
        bus.mem_data_vld = x.mem_data_vld;
        bus.mem_data     = x.mem_data;
    endtask

    task automatic clr();
        in_t z;
        z = '0;
        drive_in(z);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack and data_vld must match the head of its queue.
    always @(negedge clk) begin
        if (sb_on) begin
            if (bus.ifu_ack || bus.lsu_ack) begin
                if (gnt_q.size() == 0) unexpected("grant");
                else chk("grant", {bus.ifu_ack, bus.lsu_ack}, gnt_q.pop_front());
            end
            if (bus.ifu_data_vld) begin
                if (ifu_q.size() == 0) unexpected("ifu_data_vld");
                else chk("ifu_data", bus.ifu_data, ifu_q.pop_front());
            end
            if (bus.lsu_data_vld) begin
                if (lsu_q.size() == 0) unexpected("lsu_data_vld");
                else chk("lsu_data", bus.lsu_data, lsu_q.pop_front());
            end
        end
    end

    initial begin
        vec_t v;
        n_vec = 0;
        n_err = 0;
        sb_on = 1'b0;

        // Reset with everything active on the inputs: outputs must all read 0.
        clr();
        resetn = 1'b0;
        bus.ifu_req = 1'b1; bus.lsu_req = 1'b1; bus.mem_ack = 1'b1;
        bus.mem_data_vld = 1'b1; bus.mem_data = '1; bus.ifu_addr = '1; bus.lsu_addr = '1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", pack_out(), '0);
        end
        @(posedge clk); #1;
        clr();
        resetn = 1'b1;

        // One record per cycle, starting from IDLE with rr_last = LSU.
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000000;
        v.o.mem_req = 1; v.o.mem_addr = 32'h1c000000; vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000000; v.i.mem_ack = 1;
        v.o.ifu_ack = 1; v.o.mem_req = 1; v.o.mem_addr = 32'h1c000000; vecs.push_back(v);
        v = '0; v.o.state = 1; vecs.push_back(v);
        v = '0; v.i.mem_data_vld = 1; v.i.mem_data = 64'h0123456789abcdef;
        v.o.ifu_data_vld = 1; v.o.ifu_data = 64'h0123456789abcdef; v.o.state = 1; vecs.push_back(v);
        v = '0; vecs.push_back(v);
        v = '0; v.i.lsu_req = 1; v.i.lsu_addr = 32'h1c000100; v.i.lsu_wr = 1;
        v.i.lsu_wdata = 64'hffff0000ffff0000; v.i.lsu_wstrb = 8'h0f; v.i.mem_ack = 1;
        v.o.lsu_ack = 1; v.o.mem_req = 1; v.o.mem_addr = 32'h1c000100; v.o.mem_wr = 1;
        v.o.mem_wdata = 64'hffff0000ffff0000; v.o.mem_wstrb = 8'h0f; vecs.push_back(v);
        v = '0; v.i.mem_data_vld = 1; v.i.mem_data = 64'h5a5a;
        v.o.lsu_data_vld = 1; v.o.lsu_data = 64'h5a5a; v.o.state = 2; vecs.push_back(v);
        v = '0; v.i.mem_data_vld = 1; v.i.mem_data = 64'h77; vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000040; v.i.lsu_req = 1; v.i.lsu_addr = 32'h1c000080;
        v.i.lsu_wdata = 64'h1111; v.i.lsu_wstrb = 8'hff;
        v.o.mem_req = 1; v.o.mem_addr = 32'h1c000040; vecs.push_back(v);
        v.i.ifu_cancel = 1; v.i.mem_ack = 1;
        v.o = '0; v.o.lsu_ack = 1; v.o.mem_req = 1; v.o.mem_addr = 32'h1c000080;
        v.o.mem_wdata = 64'h1111; v.o.mem_wstrb = 8'hff; vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000040; v.i.ifu_cancel = 1;
        v.i.mem_data_vld = 1; v.i.mem_data = 64'habcd;
        v.o.lsu_data_vld = 1; v.o.lsu_data = 64'habcd; v.o.state = 2; vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000040; v.i.mem_ack = 1;
        v.o.ifu_ack = 1; v.o.mem_req = 1; v.o.mem_addr = 32'h1c000040; vecs.push_back(v);
        v = '0; v.i.ifu_cancel = 1; v.o.state = 1; vecs.push_back(v);
        v = '0; v.i.mem_data_vld = 1; v.i.mem_data = 64'h99; v.o.state = 1; vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000040; v.i.ifu_cancel = 1; v.i.mem_ack = 1;
        vecs.push_back(v);
        v = '0; v.i.ifu_req = 1; v.i.ifu_addr = 32'h1c000040; v.i.mem_ack = 1;
        v.o.ifu_ack = 1; v.o.mem_req = 1; v.o.mem_addr = 32'h1c000040; vecs.push_back(v);
        v = '0; v.i.ifu_cancel = 1; v.i.mem_data_vld = 1; v.i.mem_data = 64'h42; v.o.state = 1;
        vecs.push_back(v);
        v = '0; vecs.push_back(v);

        foreach (vecs[i]) begin
            drive_in(vecs[i].i);
            @(negedge clk);
            chk($sformatf("vec%0d", i), pack_out(), vecs[i].o);
            next();
        end
        clr();

        // Contention from reset with zero-wait memory: IFU, LSU, IFU, LSU.
        sb_on = 1'b1;
        bus.ifu_req = 1; bus.ifu_addr = 32'h1c000400;
        bus.lsu_req = 1; bus.lsu_addr = 32'h1c000500; bus.mem_ack = 1;
        resetn = 1'b0;
        next(); next();
        resetn = 1'b1;
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
        for (int k = 0; k < 8; k++) begin
            logic [63:0] d;
            d = 64'hc0de0000 + 64'(k) * 64'h1000 + 64'($urandom_range(0, 255));
            bus.mem_data_vld = k[0];
            bus.mem_data     = d;
            if (k[0]) begin
                if (k[1] == 1'b0) ifu_q.push_back(d);
                else lsu_q.push_back(d);
            end
            @(negedge clk);
            chk($sformatf("contend_req_c%0d", k), bus.mem_req, !k[0]);
            next();
        end
        clr();

        // One fetch so that rr_last = IFU, then hold mem_ack low while LSU arrives.
        bus.ifu_req = 1; bus.ifu_addr = 32'h1c000600; bus.mem_ack = 1;
        gnt_q.push_back(2'b10);
        @(negedge clk); next();
        clr(); bus.mem_data_vld = 1; bus.mem_data = 64'h600; ifu_q.push_back(64'h600);
        @(negedge clk); next();
        clr();
        bus.ifu_req = 1; bus.ifu_addr = 32'h1c000700; bus.lsu_addr = 32'h1c000780;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) bus.lsu_req = 1;
            bus.mem_ack = (k == 3);
            if (k == 3) gnt_q.push_back(2'b01);
            @(negedge clk);
            chk($sformatf("stall_addr_c%0d", k), bus.mem_addr, (k >= 2) ? 32'h1c000780 : 32'h1c000700);
            chk($sformatf("stall_req_c%0d", k), bus.mem_req, 1'b1);
            next();
        end
        bus.lsu_req = 0; bus.mem_ack = 0;
        bus.mem_data_vld = 1; bus.mem_data = 64'h780; lsu_q.push_back(64'h780);
        @(negedge clk);
        chk("stall_wait_req", bus.mem_req, 1'b0);
        next();
        bus.mem_data_vld = 0; bus.mem_ack = 1; gnt_q.push_back(2'b10);
        @(negedge clk); next();
        clr(); bus.mem_data_vld = 1; bus.mem_data = 64'h700; ifu_q.push_back(64'h700);
        @(negedge clk); next();
        clr();

        // Cancel one cycle before the response; the next fetch proceeds normally.
        bus.ifu_req = 1; bus.ifu_addr = 32'h1c000300; bus.mem_ack = 1; gnt_q.push_back(2'b10);
        @(negedge clk); next();
        clr(); bus.ifu_cancel = 1;
        @(negedge clk); next();
        clr(); bus.mem_data_vld = 1; bus.mem_data = 64'hbad;
        @(negedge clk);
        chk("cancel_ifu_vld", bus.ifu_data_vld, 1'b0);
        next();
        clr();
        @(negedge clk);
        chk("cancel_state_idle", bus.arb_state, 2'd0);
        next();
        bus.ifu_req = 1; bus.ifu_addr = 32'h1c000200; bus.mem_ack = 1; gnt_q.push_back(2'b10);
        @(negedge clk);
        chk("refetch_addr", bus.mem_addr, 32'h1c000200);
        next();
        clr(); bus.mem_data_vld = 1; bus.mem_data = 64'h0200feed; ifu_q.push_back(64'h0200feed);
        @(negedge clk); next();
        clr();

        // Reset while a load is outstanding; the late response must be dropped.
        bus.lsu_req = 1; bus.lsu_addr = 32'h1c000900; bus.mem_ack = 1; gnt_q.push_back(2'b01);
        @(negedge clk); next();
        clr();
        @(negedge clk);
        chk("midop_state", bus.arb_state, 2'd2);
        resetn = 1'b0;
        bus.ifu_req = 1; bus.lsu_req = 1; bus.mem_ack = 1; bus.mem_data_vld = 1; bus.mem_data = 64'h901;
        #1;
        chk("midop_rst_outputs", pack_out(), '0);
        next();
        @(negedge clk);
        chk("midop_rst_outputs_2", pack_out(), '0);
        next();
        clr();
        resetn = 1'b1;
        bus.mem_data_vld = 1; bus.mem_data = 64'h900;
        @(negedge clk);
        chk("stale_lsu_vld", bus.lsu_data_vld, 1'b0);
        chk("stale_state", bus.arb_state, 2'd0);
        next();
        clr();
        next();

        sb_on = 1'b0;
        chk("gnt_q_drained", gnt_q.size(), 0);
        chk("ifu_q_drained", ifu_q.size(), 0);
        chk("lsu_q_drained", lsu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
